// File: rtl/uart_transmitter.sv
// uart_transmitter: buffered 8N1 UART transmitter driving the serial TX pin
//   Parameters: CLOCK_FREQ (Hz), BAUD_RATE (bit/s), FIFO_DEPTH (power of two, >= 2)
//   Ports:
//     clk            in   CPU clock, rising edge
//     rst_n          in   synchronous active-low reset
//     data_in[7:0]   in   byte to transmit
//     data_in_valid  in   data_in offered this cycle
//     data_in_ready  out  FIFO has room this cycle
//     serial_out     out  registered UART line, idle high
//     busy           out  FIFO non-empty or frame on the line
//     fifo_count     out  buffered bytes, excluding the byte being shifted
//   Optional feature: define UART_TX_PARITY_EN to append an even-parity bit (11-symbol frame)
module uart_transmitter #(
    parameter int CLOCK_FREQ = 83_333_333,
    parameter int BAUD_RATE  = 115_200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    data_in,
    input  logic                          data_in_valid,
    output logic                          data_in_ready,
    output logic                          serial_out,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int SET = CLOCK_FREQ / BAUD_RATE;
    localparam int CW  = SET > 1 ? $clog2(SET) : 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_MAX = CW'(SET - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    data_q, data_d;
    logic          serial_q, serial_d;
    logic          push, pop, sym_end;

    assign data_in_ready = count_q != (AW+1)'(FIFO_DEPTH);
    assign push          = data_in_valid & data_in_ready;
    assign sym_end       = cnt_q == CNT_MAX;
    // Pop while idle, or on the last stop-bit cycle so the next start bit follows with no gap
    assign pop           = (count_q != '0) & ((state_q == IDLE) | ((state_q == STOP) & sym_end));
    assign serial_out    = serial_q;
    assign busy          = (state_q != IDLE) | (count_q != '0);
    assign fifo_count    = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
        state_d  = state_q;
        cnt_d    = sym_end ? '0 : cnt_q + CW'(1);
        bit_d    = bit_q;
        data_d   = pop ? mem_q[rd_ptr_q] : data_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (pop) state_d = START;
            end
            START: if (sym_end) begin
                state_d = DATA;
                bit_d   = '0;
            end
            DATA: if (sym_end) begin
                bit_d = bit_q + 3'd1;
`ifdef UART_TX_PARITY_EN
                if (bit_q == 3'd7) state_d = PARITY;
`else
                if (bit_q == 3'd7) state_d = STOP;
`endif
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (sym_end) state_d = STOP;
`endif
            STOP: if (sym_end) state_d = pop ? START : IDLE;
            default: state_d = IDLE;
        endcase
        // Line level is derived from the next state so serial_out is a clean register
        case (state_d)
            START:   serial_d = 1'b0;
            DATA:    serial_d = data_d[bit_d];
`ifdef UART_TX_PARITY_EN
            PARITY:  serial_d = ^data_d;
`endif
            default: serial_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= data_in;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            data_q   <= '0;
            serial_q <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            data_q   <= data_d;
            serial_q <= serial_d;
        end
    end
endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: self-checking bench for uart_transmitter (CLOCK_FREQ=1000, BAUD_RATE=100)
module tb_uart_transmitter;
    localparam int SYM = 10;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FR = NB * SYM;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data_in = '0;
    logic       data_in_valid = 1'b0;
    logic       data_in_ready, serial_out, busy;
    logic [3:0] fifo_count;

    uart_transmitter #(.CLOCK_FREQ(1000), .BAUD_RATE(100), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_in_valid(data_in_valid),
        .data_in_ready(data_in_ready), .serial_out(serial_out), .busy(busy), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    int errs = 0, checks = 0, cyc = 0;
    logic [7:0] exp_q [$];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic exp_level(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
        if (i == 9 && NB == 11) return ^b;
        return 1'b1;
    endfunction

    // Drives one byte; returns #1 after the handshake edge and records it in the scoreboard
    task automatic push(input logic [7:0] b);
        int t = 0;
        data_in = b;
        data_in_valid = 1'b1;
        while (!data_in_ready && t < 5000) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("push_ready_timeout", data_in_ready, 1'b1);
        @(posedge clk);
        exp_q.push_back(b);
        #1;
        data_in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while (busy && n < max) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("idle_timeout", busy, 1'b0);
    endtask

    // Line decoder: samples mid-symbol and pops expected bytes off the scoreboard
    logic       m_on = 1'b0, m_prev = 1'b1;
    int         m_t = 0, m_i;
    logic [7:0] m_byte;
    always @(negedge clk) begin
        if (!rst_n) begin
            m_on = 1'b0;
            m_prev = 1'b1;
        end else begin
            if (!m_on) begin
                if (m_prev && !serial_out) begin
                    m_on = 1'b1;
                    m_t = 0;
                end
            end else m_t++;
            if (m_on && (m_t % SYM) == SYM / 2) begin
                m_i = m_t / SYM;
                if (m_i == 0) check("start_bit", serial_out, 1'b0);
                else if (m_i <= 8) m_byte[m_i-1] = serial_out;
                else if (m_i < NB - 1) begin
                    if (exp_q.size() > 0) check("parity_bit", serial_out, ^exp_q[0]);
                end else begin
                    check("stop_bit", serial_out, 1'b1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errs++;
                        $display("FAIL rx_unexpected: got %0h expected no frame", m_byte);
                    end else check("rx_byte", m_byte, exp_q.pop_front());
                    m_on = 1'b0;
                end
            end
            m_prev = serial_out;
        end
    end

    typedef struct {
        logic [7:0] d;
        int         cnt;
        logic       rdy;
    } vec_t;
    vec_t tab [9];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, n, lows;
        for (int i = 0; i < 9; i++) begin
            tab[i].d   = 8'h80 + 8'(i * 7);
            tab[i].cnt = i < 8 ? i + 1 : 8;
            tab[i].rdy = i < 7;
        end

        repeat (3) @(posedge clk);
        #1;
        check("rst_serial", serial_out, 1'b1);
        check("rst_count", fifo_count, 4'd0);
        check("rst_ready", data_in_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single 0x55 frame, checked cycle by cycle
        push(8'h55);
        check("lat_count", fifo_count, 4'd1);
        check("lat_serial_high", serial_out, 1'b1);
        @(posedge clk);
        #1;
        for (int k = 0; k < FR; k++) begin
            check("pat55_level", serial_out, exp_level(8'h55, k / SYM));
            check("pat55_busy", busy, 1'b1);
            @(posedge clk);
            #1;
        end
        check("pat55_end_busy", busy, 1'b0);
        check("pat55_end_serial", serial_out, 1'b1);

        // Back-to-back frames, no idle gap
        push(8'hA3);
        c0 = cyc;
        push(8'h0F);
        push(8'hFF);
        wait_idle(2000);
        check("b2b_length", cyc - c0, 3 * FR + 1);
        check("b2b_drained", exp_q.size(), 0);

        // FIFO fill while a frame is on the line
        push(8'h11);
        c0 = cyc;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            push(tab[i].d);
            check("fill_count", fifo_count, tab[i].cnt);
            check("fill_ready", data_in_ready, tab[i].rdy);
        end
        n = 0;
        while (!data_in_ready && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("ready_return_cycle", cyc - c0, FR + 1);
        check("ready_return_count", fifo_count, 4'd7);
        push(tab[8].d);
        check("fill9_count", fifo_count, tab[8].cnt);
        check("fill9_ready", data_in_ready, tab[8].rdy);
        wait_idle(3000);
        check("fill_drained", exp_q.size(), 0);

        // Push and pop on the same edge with three bytes buffered
        push(8'h21);
        c0 = cyc;
        @(posedge clk);
        #1;
        push(8'h32);
        push(8'h43);
        push(8'h54);
        check("pp_pre_count", fifo_count, 4'd3);
        while (cyc < c0 + FR) begin
            @(posedge clk);
            #1;
        end
        push(8'h65);
        check("pp_count", fifo_count, 4'd3);
        check("pp_start", serial_out, 1'b0);
        wait_idle(2000);
        check("pp_drained", exp_q.size(), 0);

        // Reset during the data bits of 0x00
        push(8'h00);
        push(8'h12);
        push(8'h34);
        repeat (30) @(posedge clk);
        #1;
        check("mid_frame_low", serial_out, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("mrst_serial", serial_out, 1'b1);
        check("mrst_count", fifo_count, 4'd0);
        check("mrst_ready", data_in_ready, 1'b1);
        check("mrst_busy", busy, 1'b0);
        exp_q.delete();
        rst_n = 1'b1;
        lows = 0;
        repeat (200) begin
            @(posedge clk);
            #1;
            if (!serial_out || busy) lows++;
        end
        check("mrst_quiet", lows, 0);

`ifdef UART_TX_PARITY_EN
        for (int i = 0; i < 2; i++) begin
            logic [7:0] b;
            b = i == 0 ? 8'h07 : 8'h03;
            push(b);
            c0 = cyc;
            repeat (96) @(posedge clk);
            #1;
            check("parity_level", serial_out, i == 0 ? 1'b1 : 1'b0);
            wait_idle(500);
            check("parity_frame_len", cyc - c0, FR + 1);
        end
`endif

        check("final_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

Buffered 8N1 UART transmitter that drives the FPGA_SERIAL_TX pin from a byte stream.
- Upstream: the CPU's memory-mapped UART or a board-level test source.
- Accepts bytes on a valid/ready handshake into a small FIFO, then serialises them LSB-first at a fixed baud rate derived from the CPU clock.
- It is the transmit-direction counterpart of the serial receive path and is used at the top level alongside the CPU clock domain.

## Interface
- CLOCK_FREQ, default 83_333_333: clk frequency in Hz.
- BAUD_RATE, default 115_200: line rate in bits/s.
- FIFO_DEPTH, default 8: byte buffer entries; power of two, ≥2.
- clk  input  1  CPU clock; all logic on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- data_in  input  8  byte to transmit.
- data_in_valid  input  1  data_in is offered this cycle.
- data_in_ready  output  1  FIFO can accept a byte this cycle.
- serial_out  output  1  UART line, idle high; registered output.
- busy  output  1  high while the FIFO is non-empty or a frame is on the line.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes currently buffered, excluding the byte being shifted.

## Operation
- SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE, using integer truncation. Every line bit is held exactly that many clk cycles.
- Push: a handshake occurs when data_in_valid & data_in_ready at a rising edge. The byte is written and fifo_count increments.
- data_in_ready = (fifo_count != FIFO_DEPTH), decoded from registered state. There is no pass-through when full: a push while full is impossible because ready is low.
- Pointers wrap modulo FIFO_DEPTH. fifo_count distinguishes full from empty.
- Pop: occurs at the edge where the FSM is in IDLE (or finishing STOP) and fifo_count != 0. The popped byte loads the shift register.
- Simultaneous push and pop in one cycle leaves fifo_count unchanged and both bytes are handled correctly.
- FSM states: IDLE, START, DATA, PARITY (present only with the macro), STOP.
  - IDLE: serial_out=1. Moves to START on pop.
  - START: serial_out=0 for one symbol, then DATA.
  - DATA: sends bit[0] first, 8 symbols in total, tracked by a 3-bit bit index. Then PARITY or STOP.
  - STOP: serial_out=1 for one symbol. Then goes to START directly with a pop if the FIFO is non-empty, otherwise to IDLE.
- Back-to-back frames have no idle gap. Stop-bit length is exactly one symbol.
- busy = (state != IDLE) | (fifo_count != 0).

## Timing
- Reset (rst_n low at an edge) takes effect at that edge and gives:
  - serial_out=1
  - state=IDLE
  - fifo_count=0
  - data_in_ready=1
  - busy=0
  - the symbol counter cleared
- Reset mid-frame truncates the frame. The line returns high after that edge and buffered bytes are discarded.
- Latency when idle and empty: a handshake at edge N gives fifo_count=1 after edge N. Pop at edge N+1 takes serial_out low.
- Frame length is 10×SYMBOL_EDGE_TIME cycles, or 11× with parity.
- The symbol counter counts 0..SYMBOL_EDGE_TIME-1. The bit advances on the edge where the count equals SYMBOL_EDGE_TIME-1.
- Because data_in_ready is registered-derived, the slot freed by a pop is visible the cycle after the pop.

## Configuration
- UART_TX_PARITY_EN defined:
  - the PARITY state is compiled in;
  - one even-parity bit (XOR of the 8 data bits) is sent between DATA and STOP;
  - frame is 11 symbols.
- UART_TX_PARITY_EN undefined: no PARITY state or logic; frame is 10 symbols (8N1).

## Test plan
- Reset, CLOCK_FREQ=1000, BAUD_RATE=100, push 0x55 once:
  - serial_out low 1 cycle after the handshake;
  - line pattern 0,1,0,1,0,1,0,1,0,1 with 10 cycles per bit;
  - busy drops after 100 cycles.
- Push 0xA3, 0x0F, 0xFF back-to-back: three frames with no idle cycle between the stop bit and the next start bit. Decoded bytes match in order.
- Hold valid with 9 bytes while the line is stalled at start, FIFO_DEPTH=8:
  - ready drops after 8 handshakes, with fifo_count reading 8 after the 8th push;
  - after the first pop, ready returns the next cycle;
  - the 9th byte is accepted and transmitted last.
- Assert rst_n=0 during the DATA bits of 0x00:
  - serial_out=1 after that edge;
  - fifo_count=0, data_in_ready=1, busy=0;
  - no further edges on the line.
- Push and pop in the same cycle with fifo_count=3: fifo_count stays 3 and no byte is lost or duplicated.
- With UART_TX_PARITY_EN, push 0x07: parity bit =1 and the frame is 110 cycles. Push 0x03: parity bit =0.
